// File: rtl/cmd_ack_responder.sv
// cmd_ack_responder
//   Command-acknowledge responder on the 8-bit control byte stream. A frame is a
//   contiguous run of cycles with con_din_en high. When the first two bytes match
//   HDR0/HDR1, up to ECHO_LEN leading bytes are echoed with a fixed two-cycle
//   latency, followed directly by a 4-byte trailer: ACK_BYTE, VER_MAJ, VER_MIN and
//   the current sequence value. Frames that start while a response is still in
//   flight are discarded whole and flagged on drop.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  asynchronous reset, active-low
//   con_din      in   8  input frame byte
//   con_din_en   in   1  input byte valid (frame = contiguous high run)
//   con_dout     out  8  response byte, 0 whenever con_dout_en is low
//   con_dout_en  out  1  response byte valid
//   busy         out  1  high from the match decision until the last trailer byte
//   drop         out  1  one-cycle pulse on byte 0 of a frame rejected due to busy
//   ack_seq      out  8  sequence value carried by the next trailer
module cmd_ack_responder #(
  parameter logic [7:0] HDR0     = 8'h04,
  parameter logic [7:0] HDR1     = 8'h21,
  parameter int         ECHO_LEN = 12,
  parameter logic [7:0] ACK_BYTE = 8'haa,
  parameter logic [7:0] VER_MAJ  = 8'h01,
  parameter logic [7:0] VER_MIN  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] con_din,
  input  logic       con_din_en,
  output logic [7:0] con_dout,
  output logic       con_dout_en,
  output logic       busy,
  output logic       drop,
  output logic [7:0] ack_seq
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ECHO,
    TRAIL,
    DRAIN
  } state_t;

  localparam logic [7:0] EchoLenC = 8'(ECHO_LEN);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       prevEn_q;
  logic       ignore_q, ignore_d;
  logic [1:0] trailIdx_q, trailIdx_d;
  logic [7:0] seq_q, seq_d;
  logic [7:0] din1_q, din2_q;
  logic       vld1_q, vld2_q;
  logic       frameStart;

  // ignore_q comes out of reset set so that a frame already in progress when
  // reset is released is skipped; it is also set for a dropped frame, and any
  // idle input cycle clears it. The vld tags mark bytes still inside the echo
  // window as they travel down the two-stage delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      prevEn_q   <= 1'b0;
      ignore_q   <= 1'b1;
      trailIdx_q <= 2'd0;
      seq_q      <= 8'd0;
      din1_q     <= 8'd0;
      din2_q     <= 8'd0;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prevEn_q   <= con_din_en;
      ignore_q   <= ignore_d;
      trailIdx_q <= trailIdx_d;
      seq_q      <= seq_d;
      din1_q     <= con_din;
      din2_q     <= din1_q;
      vld1_q     <= con_din_en && (cnt_q < EchoLenC);
      vld2_q     <= vld1_q;
    end
  end

  assign frameStart = con_din_en && !prevEn_q && !ignore_q;
  assign ack_seq    = seq_q;

  // Next-state and output decode. ECHO always has a valid byte at the delay-line
  // output, and it hands over to TRAIL as soon as the byte behind it is outside
  // the echo window, which keeps con_dout_en gap-free into the trailer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = con_din_en ? cnt_q + 8'd1 : 8'd0;
    ignore_d    = ignore_q;
    trailIdx_d  = trailIdx_q;
    seq_d       = seq_q;
    con_dout    = 8'd0;
    con_dout_en = 1'b0;
    busy        = (state_q == ECHO) || (state_q == TRAIL);
    drop        = frameStart && busy;

    if (!con_din_en) begin
      ignore_d = 1'b0;
    end else if (drop) begin
      ignore_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frameStart) begin
          state_d = HDR;
        end
      end
      HDR: begin
        if (!con_din_en) begin
          state_d = IDLE;
        end else if ((din1_q == HDR0) && (con_din == HDR1)) begin
          state_d = ECHO;
        end else begin
          state_d = DRAIN;
        end
      end
      ECHO: begin
        con_dout_en = vld2_q;
        con_dout    = vld2_q ? din2_q : 8'd0;
        if (!vld1_q) begin
          state_d    = TRAIL;
          trailIdx_d = 2'd0;
        end
      end
      TRAIL: begin
        con_dout_en = 1'b1;
        trailIdx_d  = trailIdx_q + 2'd1;
        case (trailIdx_q)
          2'd0: con_dout = ACK_BYTE;
          2'd1: con_dout = VER_MAJ;
          2'd2: con_dout = VER_MIN;
          default: begin
            con_dout = seq_q;
            seq_d    = seq_q + 8'd1;
            state_d  = con_din_en ? DRAIN : IDLE;
          end
        endcase
      end
      DRAIN: begin
        if (!con_din_en) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cmd_ack_responder.sv
// Bench for cmd_ack_responder. Frames come from a small table plus hand-written
// sequences for dropped frames, reset during the trailer and sequence wrap.
// Every expected response byte is queued when its frame is driven and popped
// when the design presents a valid output byte.
module tb_cmd_ack_responder;

  typedef struct {
    int         len;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] base;
    logic [7:0] step;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] con_din;
  logic       con_din_en;
  logic [7:0] con_dout;
  logic       con_dout_en;
  logic       busy;
  logic       drop;
  logic [7:0] ack_seq;

  int         tests;
  int         failures;
  int         cyc;
  int         runLen;
  int         lastRunLen;
  int         firstOutCyc;
  int         startCyc;
  int         dropCount;
  logic [7:0] seqModel;
  logic [7:0] expQ[$];
  vec_t       vecs[9];

  cmd_ack_responder dut (
    .clk        (clk),
    .rst        (rst),
    .con_din    (con_din),
    .con_din_en (con_din_en),
    .con_dout   (con_dout),
    .con_dout_en(con_dout_en),
    .busy       (busy),
    .drop       (drop),
    .ack_seq    (ack_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: scoreboard pop, idle-value checks, run length and drop count.
  always @(negedge clk) begin
    logic [7:0] e;
    if (con_dout_en) begin
      checkOutput("busy_while_valid", 32'(busy), 32'd1);
      if (runLen == 0) firstOutCyc = cyc;
      runLen++;
      if (expQ.size() == 0) begin
        tests++;
        failures++;
        $display("[TB] FAIL unexpected_output: got %02h, required no output (cycle %0d)", con_dout, cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("dout_byte", 32'(con_dout), 32'(e));
      end
    end else begin
      checkOutput("dout_zero_when_idle", 32'(con_dout), 32'd0);
      if (expQ.size() == 0) checkOutput("busy_when_idle", 32'(busy), 32'd0);
      if (runLen != 0) begin
        lastRunLen = runLen;
        runLen     = 0;
      end
    end
    if (drop) dropCount++;
  end

  function automatic logic [7:0] frameByte(input vec_t v, input int i);
    if (i == 0) return v.b0;
    if (i == 1) return v.b1;
    return v.base + 8'(int'(v.step) * (i - 2));
  endfunction

  function automatic bit isMatch(input vec_t v);
    return (v.len >= 2) && (v.b0 == 8'h04) && (v.b1 == 8'h21);
  endfunction

  function automatic int expRun(input vec_t v);
    return ((v.len < 12) ? v.len : 12) + 4;
  endfunction

  // Drives one frame followed by one idle cycle. When the frame is expected to
  // be accepted and matches, its echo and trailer are queued.
  task automatic applyStimulus(input vec_t v, input bit accept);
    if (accept && isMatch(v)) begin
      for (int i = 0; i < v.len && i < 12; i++) expQ.push_back(frameByte(v, i));
      expQ.push_back(8'haa);
      expQ.push_back(8'h01);
      expQ.push_back(8'h00);
      expQ.push_back(seqModel);
      seqModel = seqModel + 8'd1;
    end
    for (int i = 0; i < v.len; i++) begin
      @(posedge clk);
      #1;
      con_din    = frameByte(v, i);
      con_din_en = 1'b1;
      if (i == 0) startCyc = cyc;
    end
    @(posedge clk);
    #1;
    con_din    = 8'h00;
    con_din_en = 1'b0;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !con_dout_en) done = 1'b1;
    end
    if (!done) begin
      tests++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d bytes pending, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   preDrop;
    vec_t v;
    tests       = 0;
    failures    = 0;
    cyc         = 0;
    runLen      = 0;
    lastRunLen  = 0;
    firstOutCyc = 0;
    startCyc    = 0;
    dropCount   = 0;
    seqModel    = 8'h00;
    rst         = 1'b0;
    con_din     = 8'h00;
    con_din_en  = 1'b0;

    vecs[0] = '{20, 8'h04, 8'h21, 8'h00, 8'h01};
    vecs[1] = '{20, 8'h04, 8'h21, 8'h00, 8'h01};
    vecs[2] = '{5,  8'h04, 8'h21, 8'h33, 8'h11};
    vecs[3] = '{6,  8'h04, 8'h22, 8'h10, 8'h01};
    vecs[4] = '{1,  8'h04, 8'h21, 8'h00, 8'h00};
    vecs[5] = '{4,  8'h05, 8'h21, 8'h40, 8'h03};
    vecs[6] = '{2,  8'h04, 8'h21, 8'h00, 8'h00};
    vecs[7] = '{12, 8'h04, 8'h21, 8'h80, 8'h05};
    vecs[8] = '{13, 8'h04, 8'h21, 8'hf0, 8'h01};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_dout_en", 32'(con_dout_en), 32'd0);
    checkOutput("reset_dout", 32'(con_dout), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_drop", 32'(drop), 32'd0);
    checkOutput("reset_ack_seq", 32'(ack_seq), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Table of frames, each separated by an 8-cycle idle gap.
    for (int n = 0; n < 9; n++) begin
      preDrop = dropCount;
      applyStimulus(vecs[n], 1'b1);
      waitDrain();
      repeat (8) @(posedge clk);
      checkOutput("ack_seq_after_frame", 32'(ack_seq), 32'(seqModel));
      checkOutput("no_drop", 32'(dropCount), 32'(preDrop));
      if (isMatch(vecs[n])) begin
        checkOutput("run_length", 32'(lastRunLen), 32'(expRun(vecs[n])));
        checkOutput("echo_latency", 32'(firstOutCyc - startCyc), 32'd2);
      end
    end

    // New frame one idle cycle after a matched frame: suppressed, one drop pulse.
    preDrop = dropCount;
    v = '{3, 8'h04, 8'h21, 8'h55, 8'h01};
    applyStimulus(v, 1'b1);
    v = '{3, 8'h04, 8'h21, 8'h77, 8'h01};
    applyStimulus(v, 1'b0);
    waitDrain();
    repeat (8) @(posedge clk);
    checkOutput("busy_drop_count", 32'(dropCount), 32'(preDrop + 1));
    checkOutput("busy_drop_run_length", 32'(lastRunLen), 32'd7);
    checkOutput("busy_drop_ack_seq", 32'(ack_seq), 32'(seqModel));

    // Walk the sequence up to FF with minimal frames, then cross the wrap.
    v = '{2, 8'h04, 8'h21, 8'h00, 8'h00};
    while (seqModel != 8'hff) begin
      applyStimulus(v, 1'b1);
      waitDrain();
      repeat (2) @(posedge clk);
    end
    checkOutput("ack_seq_preload", 32'(ack_seq), 32'hff);
    applyStimulus(v, 1'b1);
    waitDrain();
    repeat (4) @(posedge clk);
    checkOutput("ack_seq_wrap", 32'(ack_seq), 32'h00);

    // Reset asserted while trailer byte 2 is on the output.
    v = '{20, 8'h04, 8'h21, 8'h60, 8'h01};
    for (int i = 0; i < 12; i++) expQ.push_back(frameByte(v, i));
    expQ.push_back(8'haa);
    expQ.push_back(8'h01);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      con_din    = frameByte(v, i);
      con_din_en = 1'b1;
      if (i == 16) begin
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_trailer_reset_dout_en", 32'(con_dout_en), 32'd0);
        checkOutput("mid_trailer_reset_dout", 32'(con_dout), 32'd0);
        checkOutput("mid_trailer_reset_ack_seq", 32'(ack_seq), 32'd0);
      end
      if (i == 17) rst = 1'b1;
    end
    @(posedge clk);
    #1;
    con_din    = 8'h00;
    con_din_en = 1'b0;
    seqModel   = 8'h00;
    waitDrain();
    repeat (8) @(posedge clk);
    checkOutput("after_reset_ack_seq", 32'(ack_seq), 32'd0);

    // Normal operation resumes after the aborted frame.
    v = '{5, 8'h04, 8'h21, 8'h33, 8'h11};
    applyStimulus(v, 1'b1);
    waitDrain();
    repeat (8) @(posedge clk);
    checkOutput("resume_ack_seq", 32'(ack_seq), 32'd1);
    checkOutput("resume_run_length", 32'(lastRunLen), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
